sobel_window_buffer: RTL and testbench

// - Stage directly upstream of sobel_operator. Turns a raster pixel stream into one 3x3 neighbourhood per pixel.
// - Uses two line buffers and a 3x3 shift-register window.
// - Drives sobel_operator's packed 72-bit window input. No back-pressure: the stream is push-only.

---
 rtl/sobel_window_buffer_pkg.sv | 12 +
 rtl/sobel_window_buffer_line_buffer_ram.sv | 24 ++
 rtl/sobel_window_buffer.sv | 117 +++++++++++
 tb/tb_sobel_window_buffer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sobel_window_buffer_pkg.sv
// Shared definitions for the Sobel window buffer: tap count and FSM state encoding.
package sobel_window_buffer_pkg;

    localparam int unsigned NTAP = 9;

    typedef enum logic [1:0] {
        S_WAIT_SOF = 2'd0,
        S_FILL     = 2'd1,
        S_STREAM   = 2'd2
    } state_e;

endpackage

// File: rtl/sobel_window_buffer_line_buffer_ram.sv
// One-row line buffer: single port, read-before-write, data read from the presented column.
module line_buffer_ram #(
    parameter int DEPTH = 640,
    parameter int DW    = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DW-1:0]            din,
    output logic [DW-1:0]            dout
);

    logic [DW-1:0] mem_q [DEPTH];

    // Old contents are visible on dout during the write cycle.
    assign dout = mem_q[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= din;
        end
    end

endmodule

// File: rtl/sobel_window_buffer.sv
// Raster pixel stream to 3x3 neighbourhood: two line buffers feeding a 3x3 shift window.
module sobel_window_buffer
    import sobel_window_buffer_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PIX_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PIX_W-1:0]        pix_in,
    input  logic                    pix_valid,
    input  logic                    sof,
    output logic [NTAP*PIX_W-1:0]   window,
    output logic                    win_valid,
    output logic                    frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    state_e                         state_q, state_d;
    logic [CW-1:0]                  col_q, col_d;
    logic [RW-1:0]                  row_q, row_d;
    logic [0:2][0:2][PIX_W-1:0]     win_q, win_d;
    logic                           win_valid_q, win_valid_d;
    logic                           frame_done_q, frame_done_d;

    logic                           restart, acc, col_last, lb_we;
    logic [CW-1:0]                  rd_col;
    logic [PIX_W-1:0]               lb0_rd, lb1_rd;

    assign restart  = pix_valid && sof;
    assign acc      = pix_valid && (sof || state_q != S_WAIT_SOF);
    assign col_last = (col_q == COL_LAST);
    assign lb_we    = acc && !rst;
    // A start-of-frame pixel is column 0 regardless of where the counter stood.
    assign rd_col   = restart ? '0 : col_q;

    line_buffer_ram #(.DEPTH(IMG_WIDTH), .DW(PIX_W)) u_lb1 (
        .clk  (clk),
        .we   (lb_we),
        .addr (rd_col),
        .din  (pix_in),
        .dout (lb1_rd)
    );

    line_buffer_ram #(.DEPTH(IMG_WIDTH), .DW(PIX_W)) u_lb0 (
        .clk  (clk),
        .we   (lb_we),
        .addr (rd_col),
        .din  (lb1_rd),
        .dout (lb0_rd)
    );

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        if (acc) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb0_rd;
            win_d[1][2] = lb1_rd;
            win_d[2][2] = pix_in;
            if (restart) begin
                state_d = S_FILL;
                col_d   = CW'(1);
                row_d   = '0;
            end else begin
                win_valid_d = (state_q == S_STREAM) && (row_q >= RW'(2)) && (col_q >= CW'(2));
                col_d       = col_last ? '0 : col_q + 1'b1;
                if (col_last) begin
                    row_d = row_q + 1'b1;
                    if (state_q == S_FILL && row_q == RW'(1)) begin
                        state_d = S_STREAM;
                    end
                    if (state_q == S_STREAM && row_q == ROW_LAST) begin
                        state_d      = S_WAIT_SOF;
                        row_d        = '0;
                        frame_done_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_WAIT_SOF;
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign window     = win_q;
    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sobel_window_buffer.sv
// Scoreboard bench for sobel_window_buffer on an 8x6 image, pixel value = {row, col}.
module tb_sobel_window_buffer;

    localparam int W = 8;
    localparam int H = 6;
    localparam logic [71:0] FIRST_WIN = 72'h000102101112202122;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pix_in;
    logic        pix_valid;
    logic        sof;
    logic [71:0] window;
    logic        win_valid;
    logic        frame_done;

    sobel_window_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .sof        (sof),
        .window     (window),
        .win_valid  (win_valid),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          wv_cnt = 0;
    int          fd_cnt = 0;
    bit          fd_exp = 1'b0;
    bit          mon_en = 1'b0;
    bit          toggle_mode = 1'b0;
    logic [71:0] exp_q [$];

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [71:0] win_at(input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w = {w[63:0], 4'(r - 2 + i), 4'(c - 2 + j)};
        return w;
    endfunction

    // Monitor: snapshot stimulus at the edge, check outputs on the following negedge.
    initial begin
        bit          pv_s, rs_s, fd_s, prev_wv;
        logic [71:0] prev_win;
        prev_wv  = 1'b0;
        prev_win = '0;
        forever begin
            @(posedge clk);
            pv_s = pix_valid;
            rs_s = rst;
            fd_s = fd_exp;
            @(negedge clk);
            if (mon_en) begin
                chk("frame_done", {71'd0, frame_done}, {71'd0, fd_s});
                if (frame_done) fd_cnt++;
                if (!pv_s && !rs_s) chk("window_hold", window, prev_win);
                if (toggle_mode && win_valid) chk("wv_back_to_back", {71'd0, prev_wv}, 72'd0);
                if (win_valid) begin
                    wv_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_window: got %h expected none at %0t", window, $time);
                    end else begin
                        chk("window", window, exp_q.pop_front());
                    end
                end
            end
            prev_wv  = win_valid;
            prev_win = window;
        end
    end

    task automatic px(input logic [7:0] v, input bit valid, input bit s,
                      input bit ev, input logic [71:0] ew, input bit fd);
        pix_in    = v;
        pix_valid = valid;
        sof       = s;
        fd_exp    = fd;
        if (ev) exp_q.push_back(ew);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        pix_valid = 1'b0;
        sof       = 1'b0;
        fd_exp    = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_frame(input bit tog, input int stop_r, input int stop_c);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == stop_r && c == stop_c) return;
                px({4'(r), 4'(c)}, 1'b1, (r == 0 && c == 0), (r >= 2 && c >= 2),
                   (r == 2 && c == 2) ? FIRST_WIN : win_at(r, c),
                   (r == H - 1 && c == W - 1));
                if (tog) idle(1);
            end
        end
    endtask

    task automatic end_scn(input string name, input int exp_wv, input int exp_fd);
        idle(3);
        chk({name, "_windows"}, 72'(wv_cnt), 72'(exp_wv));
        chk({name, "_frame_done"}, 72'(fd_cnt), 72'(exp_fd));
        chk({name, "_queue_left"}, 72'(exp_q.size()), 72'd0);
        exp_q.delete();
        wv_cnt = 0;
        fd_cnt = 0;
    endtask

    initial begin
        rst       = 1'b1;
        pix_in    = '0;
        pix_valid = 1'b0;
        sof       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_window", window, 72'd0);
        chk("reset_win_valid", {71'd0, win_valid}, 72'd0);
        chk("reset_frame_done", {71'd0, frame_done}, 72'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        run_frame(1'b0, H, 0);
        end_scn("continuous", 24, 1);

        toggle_mode = 1'b1;
        run_frame(1'b1, H, 0);
        end_scn("toggled", 24, 1);
        toggle_mode = 1'b0;

        for (int i = 0; i < 5; i++) px(8'hF0 + 8'(i), 1'b1, 1'b0, 1'b0, '0, 1'b0);
        run_frame(1'b0, H, 0);
        end_scn("pre_sof", 24, 1);

        run_frame(1'b0, 3, 4);
        run_frame(1'b0, H, 0);
        end_scn("abort", 32, 1);

        run_frame(1'b0, 3, 5);
        rst       = 1'b1;
        pix_valid = 1'b1;
        sof       = 1'b0;
        pix_in    = 8'hAA;
        fd_exp    = 1'b0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        pix_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_win_valid", {71'd0, win_valid}, 72'd0);
        chk("rst_mid_window", window, 72'd0);
        for (int i = 0; i < 3; i++) px(8'h33, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        run_frame(1'b0, H, 0);
        end_scn("mid_reset", 33, 1);

        run_frame(1'b0, H, 0);
        run_frame(1'b0, H, 0);
        end_scn("back_to_back", 48, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
